// File: rtl/cpu_pkg.sv
// Shared types and constants for the 9-bit core.
package cpu_pkg;
  localparam int PC_WIDTH = 11;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_INST = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_unit.sv
// PC register, next-PC selection and start/done run control.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                   PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  START_ADDR = '0,
  parameter logic [PC_WIDTH-1:0]  PROG_LAST  = '1,
  parameter logic [INSTR_W-1:0]   HALT_INST  = cpu_pkg::HALT_INST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [INSTR_W-1:0]  inst,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                run,
  output logic                done,
  output logic [15:0]         instr_count
);
  fetch_state_t state, state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic done_n;
  logic clr;
  logic inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= START_ADDR;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    done_n  = done;
    clr     = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = ARMED;
      end
      ARMED: begin
        if (!start) state_n = RUN;
      end
      RUN: begin
        if (start) begin
          state_n = ARMED;
        end else if (inst == HALT_INST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (branch_en) begin
          pc_n = branch_target;
          inc  = 1'b1;
        end else if (pc == PROG_LAST) begin
          inc     = 1'b1;
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          pc_n = pc + 1'b1;
          inc  = 1'b1;
        end
      end
      DONE: begin
        if (start) state_n = ARMED;
      end
      default: state_n = IDLE;
    endcase
    // Entering or holding ARMED rewinds the run immediately.
    if (state_n == ARMED) begin
      pc_n   = START_ADDR;
      clr    = 1'b1;
      done_n = 1'b0;
      inc    = 1'b0;
    end
  end

  assign run = (state == RUN) && !start;

  sat_counter #(
    .WIDTH(16)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .clear(clr),
    .inc  (inc),
    .count(instr_count)
  );
endmodule
